// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART transmit feeder
package uart_pkg;

  localparam int DEFAULT_SIZE         = 8;
  localparam int DEFAULT_DEPTH        = 16;
  localparam int DEFAULT_BUSY_TIMEOUT = 64;

  typedef logic [DEFAULT_SIZE-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - byte FIFO whose head stays put until explicitly popped
module uart_sync_fifo #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [SIZE-1:0]        push_data,
  input  logic                   pop,
  output logic [SIZE-1:0]        head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [SIZE-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - buffers upstream bytes and sequences them into the UART transmitter
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int SIZE         = DEFAULT_SIZE,
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  input  logic [SIZE-1:0]        s_data,
  output logic                   s_ready,
  output logic                   tx_en,
  output logic [SIZE-1:0]        data_in,
  input  logic                   tx_busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   fifo_empty,
  output logic                   timeout_err
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  tx_state_t       state_q, state_d;
  logic            tx_en_q, tx_en_d;
  logic [SIZE-1:0] data_in_q, data_in_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            timeout_err_q, timeout_err_d;
  logic            retire;
  logic            full;
  logic [SIZE-1:0] head;

  uart_sync_fifo #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (s_valid),
    .push_data (s_data),
    .pop       (retire),
    .head      (head),
    .count     (fifo_count),
    .full      (full),
    .empty     (fifo_empty)
  );

  assign s_ready     = !full;
  assign tx_en       = tx_en_q;
  assign data_in     = data_in_q;
  assign timeout_err = timeout_err_q;

  always_comb begin
    state_d       = state_q;
    tx_en_d       = 1'b0;
    data_in_d     = data_in_q;
    timer_d       = timer_q;
    timeout_err_d = timeout_err_q;
    retire        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          data_in_d = head;
        end
        if (!fifo_empty && !tx_busy) begin
          state_d = LAUNCH;
          tx_en_d = 1'b1;
        end
      end
      LAUNCH: begin
        state_d = WAIT_BUSY;
        timer_d = '0;
      end
      // A missed busy edge leaves the head in place so it is simply relaunched.
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          retire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      tx_en_q       <= 1'b0;
      data_in_q     <= '0;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_en_q       <= tx_en_d;
      data_in_q     <= data_in_d;
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - self-checking bench for uart_tx_feeder with a simple UART busy model
module tb_uart_tx_feeder;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  byte_t      s_data;
  logic       s_ready;
  logic       tx_en;
  byte_t      data_in;
  logic       tx_busy;
  logic [4:0] fifo_count;
  logic       fifo_empty;
  logic       timeout_err;

  logic foreign_busy;
  logic model_on;
  int   m_dly;
  int   m_len;
  logic m_busy   = 1'b0;
  logic m_active = 1'b0;
  int   m_t      = 0;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  byte_t launches[$];
  int    l_cyc[$];
  logic  l_te[$];

  typedef struct {
    logic       valid;
    byte_t      data;
    logic [4:0] exp_count;
    logic       exp_ready;
  } vec_t;

  vec_t vecs[20];

  assign tx_busy = foreign_busy | m_busy;

  uart_tx_feeder dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .tx_en       (tx_en),
    .data_in     (data_in),
    .tx_busy     (tx_busy),
    .fifo_count  (fifo_count),
    .fifo_empty  (fifo_empty),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART stand-in: busy rises m_dly cycles after a launch and stays up m_len cycles.
  always @(negedge clk) begin
    if (tx_en) begin
      launches.push_back(data_in);
      l_cyc.push_back(cyc);
      l_te.push_back(timeout_err);
    end
    if (!rst || !model_on) begin
      m_active = 1'b0;
      m_busy   = 1'b0;
    end else if (tx_en) begin
      m_active = 1'b1;
      m_t      = 0;
      m_busy   = 1'b0;
    end else if (m_active) begin
      m_t++;
      m_busy = (m_t >= m_dly) && (m_t < m_dly + m_len);
      if (m_t >= m_dly + m_len) m_active = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] get_launch(input int idx);
    if (idx < launches.size()) return {24'h0, launches[idx]};
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int get_cyc(input int idx);
    if (idx < l_cyc.size()) return l_cyc[idx];
    return -100000;
  endfunction

  function automatic logic [31:0] get_te(input int idx);
    if (idx < l_te.size()) return {31'h0, l_te[idx]};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic push_byte(input byte_t b);
    int   n;
    logic acc;
    n       = 0;
    acc     = 1'b0;
    s_valid = 1'b1;
    s_data  = b;
    while (!acc && n < 2000) begin
      acc = s_ready;
      tick();
      n++;
    end
    s_valid = 1'b0;
    if (!acc) check("push_accept", {31'h0, acc}, 1);
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n;
    n = 0;
    while (fifo_count != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, {27'h0, fifo_count}, 0);
  endtask

  initial begin
    int   base;
    int   n;
    int   fall_cyc;
    int   zero_cyc;
    logic prev;
    logic bad;
    logic found;

    for (int i = 0; i < 20; i++) begin
      vecs[i] = '{1'b1, byte_t'(i), (i < 16) ? 5'(i + 1) : 5'd16, (i < 15)};
    end

    rst          = 1'b0;
    s_valid      = 1'b0;
    s_data       = '0;
    foreign_busy = 1'b0;
    model_on     = 1'b1;
    m_dly        = 2;
    m_len        = 10;
    repeat (2) tick();
    check("reset_s_ready", {31'h0, s_ready}, 1);
    check("reset_tx_en", {31'h0, tx_en}, 0);
    check("reset_data_in", {24'h0, data_in}, 0);
    check("reset_count", {27'h0, fifo_count}, 0);
    check("reset_empty", {31'h0, fifo_empty}, 1);
    check("reset_timeout_err", {31'h0, timeout_err}, 0);
    rst = 1'b1;
    tick();

    // Single byte through the model.
    base = launches.size();
    push_byte(8'hA5);
    check("t1_count_after_push", {27'h0, fifo_count}, 1);
    check("t1_no_launch_push_cycle", {31'h0, tx_en}, 0);
    tick();
    check("t1_launch", {31'h0, tx_en}, 1);
    check("t1_data", {24'h0, data_in}, 32'hA5);
    prev = tx_busy; fall_cyc = -1; zero_cyc = -1; bad = 1'b0; n = 0;
    while (fifo_count != 0 && n < 60) begin
      tick();
      n++;
      if (prev && !tx_busy && fall_cyc < 0) fall_cyc = cyc;
      if (fifo_count == 0) zero_cyc = cyc;
      else if (data_in != 8'hA5) bad = 1'b1;
      prev = tx_busy;
    end
    check("t1_retire_after_busy_fall", zero_cyc, fall_cyc + 1);
    check("t1_data_stable", {31'h0, bad}, 0);
    repeat (10) tick();
    check("t1_single_pulse", launches.size() - base, 1);
    check("t1_logged_byte", get_launch(base), 32'hA5);

    // Burst fill against a held foreign busy, table-driven.
    foreign_busy = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      s_valid = vecs[i].valid;
      s_data  = vecs[i].data;
      tick();
      check($sformatf("t2_count_%0d", i), {27'h0, fifo_count}, {27'h0, vecs[i].exp_count});
      check($sformatf("t2_ready_%0d", i), {31'h0, s_ready}, {31'h0, vecs[i].exp_ready});
      check($sformatf("t2_no_tx_en_%0d", i), {31'h0, tx_en}, 0);
    end
    s_valid      = 1'b0;
    base         = launches.size();
    m_len        = 3;
    foreign_busy = 1'b0;
    for (int i = 16; i < 20; i++) push_byte(byte_t'(i));
    wait_empty("t2_drain", 1000);
    check("t2_launch_total", launches.size() - base, 20);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("t2_order_%0d", i), get_launch(base + i), i);
    end

    // Foreign busy already high before the push.
    foreign_busy = 1'b1;
    base = launches.size();
    push_byte(8'h11);
    repeat (10) tick();
    check("t5_no_launch_while_busy", launches.size() - base, 0);
    check("t5_count_held", {27'h0, fifo_count}, 1);
    foreign_busy = 1'b0;
    tick();
    check("t5_launch_after_drop", {31'h0, tx_en}, 1);
    check("t5_data", {24'h0, data_in}, 32'h11);
    wait_empty("t5_drain", 200);

    // Busy never rises: repeated relaunch at BUSY_TIMEOUT+2 spacing.
    model_on = 1'b0;
    base = launches.size();
    push_byte(8'h3C);
    n = 0;
    while (launches.size() - base < 3 && n < 400) begin
      tick();
      n++;
    end
    check("t3_three_launches", launches.size() - base, 3);
    check("t3_period_1", get_cyc(base + 1) - get_cyc(base), 66);
    check("t3_period_2", get_cyc(base + 2) - get_cyc(base + 1), 66);
    check("t3_err_before_expiry", get_te(base), 0);
    check("t3_err_after_expiry", get_te(base + 1), 1);
    check("t3_data_relaunch", get_launch(base + 2), 32'h3C);
    check("t3_timeout_err", {31'h0, timeout_err}, 1);
    check("t3_count_held", {27'h0, fifo_count}, 1);

    // Reset while WAIT_DONE with five entries held.
    model_on = 1'b1;
    m_len    = 20;
    for (int i = 0; i < 4; i++) push_byte(byte_t'(8'h41 + i));
    check("t6_count_filled", {27'h0, fifo_count}, 5);
    n = 0;
    while (!tx_busy && n < 300) begin
      tick();
      n++;
    end
    check("t6_busy_seen", {31'h0, tx_busy}, 1);
    tick();
    check("t6_count_in_flight", {27'h0, fifo_count}, 5);
    check("t6_err_still_set", {31'h0, timeout_err}, 1);
    rst = 1'b0;
    #1;
    check("t6_rst_tx_en", {31'h0, tx_en}, 0);
    check("t6_rst_count", {27'h0, fifo_count}, 0);
    check("t6_rst_s_ready", {31'h0, s_ready}, 1);
    check("t6_rst_timeout_err", {31'h0, timeout_err}, 0);
    check("t6_rst_empty", {31'h0, fifo_empty}, 1);
    repeat (2) tick();
    rst  = 1'b1;
    base = launches.size();
    repeat (30) tick();
    check("t6_no_launch_after_release", launches.size() - base, 0);

    // Push lands in the same cycle the head retires.
    m_len        = 4;
    foreign_busy = 1'b1;
    push_byte(8'h21);
    push_byte(8'h22);
    push_byte(8'h23);
    base         = launches.size();
    foreign_busy = 1'b0;
    n = 0;
    while (launches.size() - base < 1 && n < 50) begin
      tick();
      n++;
    end
    prev = tx_busy; found = 1'b0; n = 0;
    while (!found && n < 100) begin
      tick();
      n++;
      if (prev && !tx_busy) found = 1'b1;
      else prev = tx_busy;
    end
    check("t4_fall_seen", {31'h0, found}, 1);
    check("t4_count_at_fall", {27'h0, fifo_count}, 3);
    s_valid = 1'b1;
    s_data  = 8'h77;
    tick();
    s_valid = 1'b0;
    check("t4_count_push_and_retire", {27'h0, fifo_count}, 3);
    wait_empty("t4_drain", 300);
    check("t4_order_0", get_launch(base), 32'h21);
    check("t4_order_1", get_launch(base + 1), 32'h22);
    check("t4_order_2", get_launch(base + 2), 32'h23);
    check("t4_order_3", get_launch(base + 3), 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
